// File: rtl/ld_st_dcache_arbiter.sv
// ============================================================================
//  Module   : ld_st_dcache_arbiter
//  Brief    : Arbitrates a load buffer and a store buffer onto one dcache port,
//             one transaction outstanding, with store anti-starvation and flush.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ld_st_dcache_arbiter #(
    parameter int ROB_ID_WIDTH = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    ld_req_valid,
    output logic                    ld_req_ready,
    input  logic [31:0]             ld_req_addr,
    input  logic [2:0]              ld_req_width,
    input  logic [ROB_ID_WIDTH-1:0] ld_req_rob_id,

    input  logic                    st_req_valid,
    output logic                    st_req_ready,
    input  logic [31:0]             st_req_addr,
    input  logic [31:0]             st_req_data,
    input  logic [2:0]              st_req_width,

    output logic                    dc_req_valid,
    input  logic                    dc_req_ready,
    output logic                    dc_req_we,
    output logic [31:0]             dc_req_addr,
    output logic [31:0]             dc_req_wdata,
    output logic [2:0]              dc_req_width,

    input  logic                    dc_resp_valid,
    input  logic [31:0]             dc_resp_data,

    output logic                    ld_resp_valid,
    output logic [ROB_ID_WIDTH-1:0] ld_resp_rob_id,
    output logic [31:0]             ld_resp_data,

    input  logic                    flush,
    output logic                    busy
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;

    localparam int                 c_CNT_W      = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_LIMIT);

    logic [1:0]              r_state;
    logic [1:0]              w_next_state;
    logic [c_CNT_W-1:0]      r_starve_cnt;
    logic                    r_kill;
    logic                    r_we;
    logic [31:0]             r_addr;
    logic [31:0]             r_wdata;
    logic [2:0]              r_width;
    logic [ROB_ID_WIDTH-1:0] r_rob_id;
    logic                    r_ld_resp_valid;
    logic [ROB_ID_WIDTH-1:0] r_ld_resp_rob_id;
    logic [31:0]             r_ld_resp_data;
    logic                    w_ld_grant;
    logic                    w_st_grant;
    logic                    w_resp_done;
    logic                    w_ld_done;

    // Grants are only issued from IDLE; a flush hides the load so a waiting
    // store can still take the slot in that cycle.
    always_comb begin
        w_ld_grant   = 1'b0;
        w_st_grant   = 1'b0;
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (!rst) begin
                    if (st_req_valid && (!ld_req_valid || flush || (r_starve_cnt == c_STARVE_MAX))) begin
                        w_st_grant = 1'b1;
                    end else if (ld_req_valid && !flush) begin
                        w_ld_grant = 1'b1;
                    end
                end
                if (w_ld_grant || w_st_grant) begin
                    w_next_state = c_REQ;
                end
            end
            c_REQ: begin
                if (dc_req_ready) begin
                    w_next_state = c_WAIT;
                end
            end
            c_WAIT: begin
                if (dc_resp_valid) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    assign w_resp_done = (r_state == c_WAIT) && dc_resp_valid;
    assign w_ld_done   = w_resp_done && !r_we && !r_kill && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= c_IDLE;
            r_starve_cnt     <= '0;
            r_kill           <= 1'b0;
            r_we             <= 1'b0;
            r_addr           <= '0;
            r_wdata          <= '0;
            r_width          <= '0;
            r_rob_id         <= '0;
            r_ld_resp_valid  <= 1'b0;
            r_ld_resp_rob_id <= '0;
            r_ld_resp_data   <= '0;
        end else begin
            r_state         <= w_next_state;
            r_ld_resp_valid <= w_ld_done;
            if (w_ld_done) begin
                r_ld_resp_rob_id <= r_rob_id;
                r_ld_resp_data   <= dc_resp_data;
            end

            if (w_ld_grant) begin
                r_we     <= 1'b0;
                r_addr   <= ld_req_addr;
                r_wdata  <= '0;
                r_width  <= ld_req_width;
                r_rob_id <= ld_req_rob_id;
                r_kill   <= 1'b0;
                if (st_req_valid && (r_starve_cnt != c_STARVE_MAX)) begin
                    r_starve_cnt <= r_starve_cnt + 1'b1;
                end
            end else if (w_st_grant) begin
                r_we         <= 1'b1;
                r_addr       <= st_req_addr;
                r_wdata      <= st_req_data;
                r_width      <= st_req_width;
                r_rob_id     <= '0;
                r_kill       <= 1'b0;
                r_starve_cnt <= '0;
            end else if (w_resp_done) begin
                r_kill <= 1'b0;
            end else if (flush && !r_we && ((r_state == c_REQ) || (r_state == c_WAIT))) begin
                // Committed stores are never killed; only loads lose their result.
                r_kill <= 1'b1;
            end
        end
    end

    assign ld_req_ready   = w_ld_grant;
    assign st_req_ready   = w_st_grant;
    assign dc_req_valid   = (r_state == c_REQ);
    assign dc_req_we      = r_we;
    assign dc_req_addr    = r_addr;
    assign dc_req_wdata   = r_wdata;
    assign dc_req_width   = r_width;
    assign ld_resp_valid  = r_ld_resp_valid;
    assign ld_resp_rob_id = r_ld_resp_rob_id;
    assign ld_resp_data   = r_ld_resp_data;
    assign busy           = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ld_st_dcache_arbiter.sv
// ============================================================================
//  Module   : tb_ld_st_dcache_arbiter
//  Brief    : Scoreboard bench for ld_st_dcache_arbiter, directed + random.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ld_st_dcache_arbiter;

    localparam int c_LIMIT = 4;
    localparam int c_RW    = 5;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  width;
    } dc_t;

    typedef struct packed {
        logic [c_RW-1:0] rob;
        logic [31:0]     data;
    } lr_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            ld_req_valid, ld_req_ready;
    logic [31:0]     ld_req_addr;
    logic [2:0]      ld_req_width;
    logic [c_RW-1:0] ld_req_rob_id;
    logic            st_req_valid, st_req_ready;
    logic [31:0]     st_req_addr, st_req_data;
    logic [2:0]      st_req_width;
    logic            dc_req_valid, dc_req_ready, dc_req_we;
    logic [31:0]     dc_req_addr, dc_req_wdata;
    logic [2:0]      dc_req_width;
    logic            dc_resp_valid;
    logic [31:0]     dc_resp_data;
    logic            ld_resp_valid;
    logic [c_RW-1:0] ld_resp_rob_id;
    logic [31:0]     ld_resp_data;
    logic            flush, busy;

    ld_st_dcache_arbiter #(.ROB_ID_WIDTH(c_RW), .STARVE_LIMIT(c_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_addr(ld_req_addr),
        .ld_req_width(ld_req_width), .ld_req_rob_id(ld_req_rob_id),
        .st_req_valid(st_req_valid), .st_req_ready(st_req_ready), .st_req_addr(st_req_addr),
        .st_req_data(st_req_data), .st_req_width(st_req_width),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_we(dc_req_we),
        .dc_req_addr(dc_req_addr), .dc_req_wdata(dc_req_wdata), .dc_req_width(dc_req_width),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .ld_resp_valid(ld_resp_valid), .ld_resp_rob_id(ld_resp_rob_id), .ld_resp_data(ld_resp_data),
        .flush(flush), .busy(busy)
    );

    always #5 clk = ~clk;

    int  tests = 0;
    int  fails = 0;
    dc_t dcq[$];
    lr_t lq[$];
    bit  fix_payload = 1'b0;

    function automatic void check(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Transaction-level reference: one slot, a starvation tally, a kill flag.
    bit              m_idle = 1'b1;
    bit              m_sent = 1'b0;
    bit              m_is_ld = 1'b0;
    bit              m_kill = 1'b0;
    bit              m_resp_due = 1'b0;
    int              m_starve = 0;
    logic [c_RW-1:0] m_rob = '0;

    always @(negedge clk) begin
        bit  g_ld, g_st;
        dc_t d;
        g_ld = 1'b0;
        g_st = 1'b0;
        if (!rst && m_idle) begin
            if (st_req_valid && (!ld_req_valid || flush || m_starve == c_LIMIT)) g_st = 1'b1;
            else if (ld_req_valid && !flush) g_ld = 1'b1;
        end
        check("ld_req_ready", 72'(ld_req_ready), 72'(g_ld));
        check("st_req_ready", 72'(st_req_ready), 72'(g_st));
        if (!rst) begin
            check("busy", 72'(busy), 72'(!m_idle));
            check("dc_req_valid", 72'(dc_req_valid), 72'(!m_idle && !m_sent));
            check("ld_resp_valid", 72'(ld_resp_valid), 72'(m_resp_due));
        end
        m_resp_due = 1'b0;
        if (rst) begin
            m_idle   = 1'b1;
            m_kill   = 1'b0;
            m_starve = 0;
            dcq.delete();
        end else if (g_ld || g_st) begin
            d.we    = g_st;
            d.addr  = g_st ? st_req_addr  : ld_req_addr;
            d.wdata = g_st ? st_req_data  : 32'h0;
            d.width = g_st ? st_req_width : ld_req_width;
            dcq.push_back(d);
            m_idle  = 1'b0;
            m_sent  = 1'b0;
            m_is_ld = g_ld;
            m_kill  = 1'b0;
            m_rob   = ld_req_rob_id;
            if (g_st) m_starve = 0;
            else if (st_req_valid && m_starve < c_LIMIT) m_starve++;
        end else if (!m_idle) begin
            if (m_is_ld && flush) m_kill = 1'b1;
            if (!m_sent) begin
                if (dc_req_ready) m_sent = 1'b1;
            end else if (dc_resp_valid) begin
                m_idle = 1'b1;
                if (m_is_ld && !m_kill) begin
                    lq.push_back('{rob: m_rob, data: dc_resp_data});
                    m_resp_due = 1'b1;
                end
            end
        end
    end

    // Monitor: matches whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        dc_t e;
        lr_t r;
        if (!rst && dc_req_valid === 1'b1) begin
            if (dcq.size() == 0) begin
                check("dc_req_unexpected", 72'(dc_req_valid), 72'(0));
            end else begin
                e = dcq[0];
                check("dc_req_we", 72'(dc_req_we), 72'(e.we));
                check("dc_req_addr", 72'(dc_req_addr), 72'(e.addr));
                check("dc_req_wdata", 72'(dc_req_wdata), 72'(e.wdata));
                check("dc_req_width", 72'(dc_req_width), 72'(e.width));
                if (dc_req_ready) void'(dcq.pop_front());
            end
        end
        if (ld_resp_valid === 1'b1) begin
            if (lq.size() == 0) begin
                check("ld_resp_unexpected", 72'(ld_resp_valid), 72'(0));
            end else begin
                r = lq.pop_front();
                check("ld_resp_rob_id", 72'(ld_resp_rob_id), 72'(r.rob));
                check("ld_resp_data", 72'(ld_resp_data), 72'(r.data));
            end
        end
    end

    task automatic step(input bit ldv, input bit stv, input bit rdy, input bit resp,
                        input bit fl, input bit r);
        ld_req_valid  = ldv;
        st_req_valid  = stv;
        dc_req_ready  = rdy;
        dc_resp_valid = resp;
        flush         = fl;
        rst           = r;
        if (!fix_payload) begin
            ld_req_addr   = $urandom;
            ld_req_width  = 3'($urandom_range(0, 7));
            ld_req_rob_id = c_RW'($urandom);
            st_req_addr   = $urandom;
            st_req_data   = $urandom;
            st_req_width  = 3'($urandom_range(0, 7));
            dc_resp_data  = $urandom;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Single load: grant, handshake, response, completion one cycle later.
        fix_payload   = 1'b1;
        ld_req_addr   = 32'h100;
        ld_req_rob_id = 5'd3;
        ld_req_width  = 3'b010;
        dc_resp_data  = 32'hDEADBEEF;
        step(1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Single store.
        st_req_addr  = 32'h200;
        st_req_data  = 32'h1234;
        st_req_width = 3'b010;
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        fix_payload = 1'b0;

        // Both always valid: four loads then a store, repeating.
        repeat (20) step(1, 1, 1, 1, 0, 0);
        repeat (3) step(0, 0, 1, 1, 0, 0);

        // dcache stalls the request for three cycles.
        step(1, 0, 0, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Flush while the load waits, then a normal load.
        step(1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Reset while waiting; the late response must be ignored.
        step(1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        repeat (3000) begin
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 1);
        end

        repeat (10) step(0, 0, 1, 1, 0, 0);
        check("dc_queue_drained", 72'(dcq.size()), 72'(0));
        check("ld_queue_drained", 72'(lq.size()), 72'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
